// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   state_t            : frame FSM states (IDLE, SHIFT)
//   DEFAULT_DATA_WIDTH : default bits per SPI word
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings one asynchronous input into the clk domain through SYNC_STAGES
// flops, then compares against one further registered copy to produce
// single-cycle rise/fall strobes.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (clears every flop to 0)
//   din  : asynchronous input
//   rise : one-cycle strobe on a synchronized 0->1 transition
//   fall : one-cycle strobe on a synchronized 1->0 transition
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_sr;
  logic                   sync_prev;
  logic                   sync_lvl;

  assign sync_lvl = sync_sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr   <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_sr   <= (sync_sr << 1) | SYNC_STAGES'(din);
      sync_prev <= sync_lvl;
    end
  end

  // Clearing to 0 means a chip select already low at reset release never
  // produces a falling edge; a fresh high->low transition is required.
  assign rise = sync_lvl & ~sync_prev;
  assign fall = ~sync_lvl & sync_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by the system clock.
// Ports:
//   clk       : system clock (single clock domain)
//   rst       : synchronous active-high reset
//   sclk      : SPI clock from master (asynchronous)
//   cs_n      : active-low chip select (asynchronous)
//   mosi      : master-out serial data (asynchronous)
//   miso      : slave-out serial data, MSB first, 0 while idle
//   tx_data   : word returned to the master, sampled at load points only
//   rx_data   : last complete received word
//   rx_valid  : one-cycle strobe, rx_data updated
//   frame_err : one-cycle strobe, chip select released mid-word
//   busy      : high while a frame is active
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  logic                   sclk_rise, sclk_fall;
  logic                   cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   mosi_s;

  state_t                 state, state_nxt;
  logic                   load_first, end_frame;
  logic                   word_done, mid_word;

  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-1:0]  rx_sr;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   reload_pend;

  // Synchronizers: sclk and cs_n with edge detect, mosi level only.
  // mosi has the same depth as sclk, so at a detected sclk rise mosi_s
  // holds the bit the master presented before that edge.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sr <= '0;
    end else begin
      mosi_sr <= (mosi_sr << 1) | SYNC_STAGES'(mosi);
    end
  end

  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  // Frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    end_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt  = SHIFT;
          load_first = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          end_frame = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full counter is retired one cycle after the final rising edge; a
  // frame ending exactly then still delivers its word, never an error.
  assign word_done = (state == SHIFT) && (bit_cnt == CNT_FULL);
  assign mid_word  = end_frame && (bit_cnt != '0) && (bit_cnt != CNT_FULL);

  // Shift datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (load_first) begin
        tx_sr       <= tx_data;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (state == SHIFT) begin
        // The falling edge after a completed word loads the next tx word
        // instead of shifting, so back-to-back words start on their MSB.
        if (sclk_fall) begin
          if (reload_pend) begin
            tx_sr       <= tx_data;
            reload_pend <= 1'b0;
          end else begin
            tx_sr <= tx_sr << 1;
          end
        end
        if (word_done) begin
          rx_data     <= rx_sr;
          rx_valid    <= 1'b1;
          bit_cnt     <= '0;
          reload_pend <= 1'b1;
        end else if (sclk_rise) begin
          rx_sr   <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (mid_word) begin
          frame_err <= 1'b1;
        end
        // Clearing tx_sr on frame end keeps miso low throughout IDLE.
        if (end_frame) begin
          tx_sr       <= '0;
          bit_cnt     <= '0;
          reload_pend <= 1'b0;
        end
      end
    end
  end

  assign miso = tx_sr[DATA_WIDTH-1];
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave: a mode-0 master model drives 5 MHz
// sclk against a 100 MHz clk; received words are scoreboarded.
module tb_spi_slave;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] tx_data = '0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int ferr_cnt = 0;
  int excl_viol = 0;
  logic [W-1:0] exp_rx_q[$];

  logic [W-1:0] got_miso;
  logic [W-1:0] dummy;
  logic         miso_or;
  logic         busy_or;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() > 0) chk("rx_data", {16'h0, rx_data}, {16'h0, exp_rx_q.pop_front()});
      end
      if (frame_err) ferr_cnt++;
      if (rx_valid && frame_err) excl_viol++;
    end
  end

  // Mode-0 master: present bit, rise (sample miso), fall. tx_data is
  // scrambled mid-word and set to next_tx just before the final rise.
  task automatic spi_bits(input logic [W-1:0] word, input int nbits,
                          input logic [W-1:0] next_tx, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[W-1-i];
      if (i == 8) tx_data = W'($urandom);
      if (i == nbits - 1) tx_data = next_tx;
      #100;
      got  = {got[W-2:0], miso};
      sclk = 1'b1;
      #100;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic idle_toggle(input int n);
    miso_or = 1'b0;
    busy_or = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom);
      #100;
      miso_or = miso_or | miso;
      busy_or = busy_or | busy;
      sclk = 1'b1;
      #100;
      sclk = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", {16'h0, rx_data}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_miso", {31'h0, miso}, 32'h0);
    rst = 1'b0;
    #200;

    // Single word
    tx_data = 16'h1234;
    cs_low();
    chk("t1_busy", {31'h0, busy}, 32'h1);
    exp_rx_q.push_back(16'hA5C3);
    spi_bits(16'hA5C3, W, 16'h1234, got_miso);
    chk("t1_miso_word", {16'h0, got_miso}, 32'h1234);
    cs_high();
    chk("t1_rx_cnt", rx_cnt, 1);
    chk("t1_ferr_cnt", ferr_cnt, 0);
    chk("t1_busy_end", {31'h0, busy}, 32'h0);
    chk("t1_miso_idle", {31'h0, miso}, 32'h0);
    chk("t1_rx_hold", {16'h0, rx_data}, 32'hA5C3);

    // Two back-to-back words in one frame
    tx_data = 16'h1234;
    cs_low();
    exp_rx_q.push_back(16'h0001);
    spi_bits(16'h0001, W, 16'hBEEF, got_miso);
    chk("t2_miso_w0", {16'h0, got_miso}, 32'h1234);
    exp_rx_q.push_back(16'hFFFF);
    spi_bits(16'hFFFF, W, 16'hBEEF, got_miso);
    chk("t2_miso_w1", {16'h0, got_miso}, 32'hBEEF);
    cs_high();
    chk("t2_rx_cnt", rx_cnt, 3);
    chk("t2_ferr_cnt", ferr_cnt, 0);

    // Frame aborted after 7 bits
    cs_low();
    spi_bits(16'h5500, 7, tx_data, dummy);
    cs_high();
    chk("t3_ferr_cnt", ferr_cnt, 1);
    chk("t3_rx_cnt", rx_cnt, 3);
    chk("t3_rx_hold", {16'h0, rx_data}, 32'hFFFF);
    chk("t3_busy", {31'h0, busy}, 32'h0);

    // sclk activity with chip select high
    idle_toggle(16);
    #200;
    chk("t4_rx_cnt", rx_cnt, 3);
    chk("t4_ferr_cnt", ferr_cnt, 1);
    chk("t4_miso", {31'h0, miso_or}, 32'h0);
    chk("t4_busy", {31'h0, busy_or}, 32'h0);

    // Reset mid-word with chip select held low
    tx_data = 16'h00FF;
    cs_low();
    spi_bits(16'h3C3C, 9, tx_data, dummy);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    chk("t5_rx_data", {16'h0, rx_data}, 32'h0);
    chk("t5_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("t5_frame_err", {31'h0, frame_err}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    chk("t5_miso", {31'h0, miso}, 32'h0);
    idle_toggle(8);
    chk("t5_no_frame_busy", {31'h0, busy_or}, 32'h0);
    chk("t5_no_frame_miso", {31'h0, miso_or}, 32'h0);
    cs_high();
    chk("t5_rx_cnt", rx_cnt, 3);
    chk("t5_ferr_cnt", ferr_cnt, 1);
    tx_data = 16'hC0DE;
    cs_low();
    exp_rx_q.push_back(16'h5A5A);
    spi_bits(16'h5A5A, W, 16'hC0DE, got_miso);
    chk("t5_miso_word", {16'h0, got_miso}, 32'hC0DE);
    cs_high();
    chk("t5_rx_cnt_after", rx_cnt, 4);
    chk("t5_rx_data_after", {16'h0, rx_data}, 32'h5A5A);
    chk("t5_ferr_after", ferr_cnt, 1);

    chk("excl", excl_viol, 0);
    chk("q_empty", exp_rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
